user_mem_sequencer: RTL



---
 rtl/user_mem_pkg.sv | 33 +++
 rtl/user_mem_sequencer_rd_timeout.sv | 31 +++
 rtl/user_mem_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/user_mem_pkg.sv
// Shared types and helpers for the user memory sequencer.
//   state_t    : sequencer FSM states
//   Def*Code   : default mailbox flag values written back to the host
//   byte_swap  : reverses the low nbytes bytes of a word (upper bits zero)
package user_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRdWait,
        StDone,
        StError
    } state_t;

    localparam logic [31:0] DefAckCode  = 32'd2;
    localparam logic [31:0] DefDoneCode = 32'd4;
    localparam logic [31:0] DefErrCode  = 32'd8;

    localparam int unsigned MaxDataW = 256;

    function automatic logic [MaxDataW-1:0] byte_swap(input logic [MaxDataW-1:0] din,
                                                     input int unsigned nbytes);
        logic [MaxDataW-1:0] dout;
        dout = '0;
        for (int unsigned i = 0; i < MaxDataW / 8; i++) begin
            if (i < nbytes) begin
                dout[8*i +: 8] = din[8*(nbytes-1-i) +: 8];
            end
        end
        return dout;
    endfunction

endpackage

// File: rtl/user_mem_sequencer_rd_timeout.sv
// Read timeout counter.
//   load   : clear the count (a new read has been issued)
//   en     : one more RD_WAIT cycle passed without read data
//   expire : high on the LIMIT-th consecutive enabled cycle
module rd_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CntW = $clog2(LIMIT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = en && (cnt_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/user_mem_sequencer.sv
// Sequences user read/write requests onto a simple memory port, gated by a
// host mailbox protocol (start/abort commands written to FLAG_ADDR).
//   host side   : pci_input_data, pci_req_addr, pci_wr_en
//   memory side : rd_req, FPGA_wr_en, req_addr, write_data, rd_data, rd_ready
//   mailbox     : flag_we, out_flag (ack / done / error write-back)
//   user side   : user_req, user_rd_wr, user_addr, user_wdata, user_set_done,
//                 user_ready, user_gnt, user_rd_data, user_rd_valid, op_count
// Memory strobes and flag writes respond combinationally in the request cycle.
module user_mem_sequencer
    import user_mem_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 21,
    parameter int unsigned          DATA_W     = 32,
    parameter logic [ADDR_W-1:0]    FLAG_ADDR  = 21'h07FFFE,
    parameter logic [DATA_W-1:0]    START_CODE = 32'h0001_0000,
    parameter logic [DATA_W-1:0]    ABORT_CODE = 32'h0008_0000,
    parameter logic [31:0]          ACK_CODE   = DefAckCode,
    parameter logic [31:0]          DONE_CODE  = DefDoneCode,
    parameter logic [31:0]          ERR_CODE   = DefErrCode,
    parameter bit                   SWAP_EN    = 1'b1,
    parameter int unsigned          RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pci_input_data,
    input  logic [ADDR_W-1:0] pci_req_addr,
    input  logic              pci_wr_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    input  logic              user_req,
    input  logic              user_rd_wr,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [DATA_W-1:0] user_wdata,
    input  logic              user_set_done,
    output logic              rd_req,
    output logic              FPGA_wr_en,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              flag_we,
    output logic [DATA_W-1:0] out_flag,
    output logic              user_ready,
    output logic              user_gnt,
    output logic [DATA_W-1:0] user_rd_data,
    output logic              user_rd_valid,
    output logic [15:0]       op_count
);

    function automatic logic [DATA_W-1:0] swap(input logic [DATA_W-1:0] d);
        if (SWAP_EN) begin
            return DATA_W'(byte_swap(MaxDataW'(d), DATA_W / 8));
        end
        return d;
    endfunction

    state_t            state_q;
    logic [15:0]       op_count_q;
    logic              done_pending_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] user_rd_data_q;
    logic              user_rd_valid_q;

    // Qualified with rst_n so nothing leaks out combinationally during reset.
    logic start_wr, abort_wr;
    assign start_wr = rst_n && pci_wr_en && (pci_req_addr == FLAG_ADDR) &&
                      (pci_input_data == START_CODE);
    assign abort_wr = rst_n && pci_wr_en && (pci_req_addr == FLAG_ADDR) &&
                      (pci_input_data == ABORT_CODE);

    // Abort outranks a same-cycle user request.
    logic wr_gnt, rd_gnt;
    assign wr_gnt = (state_q == StWait) && !abort_wr && user_req && user_rd_wr;
    assign rd_gnt = (state_q == StWait) && !abort_wr && user_req && !user_rd_wr;

    logic [15:0] op_count_inc;
    assign op_count_inc = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;

    logic tmo_expire;

    rd_timeout_ctr #(
        .LIMIT (RD_TIMEOUT)
    ) u_rd_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (rd_gnt),
        .en     ((state_q == StRdWait) && !rd_ready && !abort_wr),
        .expire (tmo_expire)
    );

    always_comb begin
        rd_req     = 1'b0;
        FPGA_wr_en = 1'b0;
        req_addr   = '0;
        write_data = '0;
        flag_we    = 1'b0;
        out_flag   = '0;
        user_ready = 1'b0;
        user_gnt   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_wr) begin
                    flag_we  = 1'b1;
                    out_flag = DATA_W'(ACK_CODE);
                    req_addr = FLAG_ADDR;
                end
            end
            StWait: begin
                user_ready = 1'b1;
                if (wr_gnt || rd_gnt) begin
                    user_gnt = 1'b1;
                    req_addr = user_addr;
                end
                if (wr_gnt) begin
                    FPGA_wr_en = 1'b1;
                    write_data = swap(user_wdata);
                end
                rd_req = rd_gnt;
            end
            StRdWait: begin
                rd_req   = 1'b1;
                req_addr = rd_addr_q;
            end
            StDone: begin
                flag_we  = 1'b1;
                req_addr = FLAG_ADDR;
                out_flag = DATA_W'({op_count_q, DONE_CODE[15:0]});
            end
            StError: begin
                flag_we  = 1'b1;
                req_addr = FLAG_ADDR;
                out_flag = DATA_W'({op_count_q, ERR_CODE[15:0]});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            op_count_q      <= '0;
            done_pending_q  <= 1'b0;
            rd_addr_q       <= '0;
            user_rd_data_q  <= '0;
            user_rd_valid_q <= 1'b0;
        end else begin
            user_rd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_wr) begin
                        state_q        <= StWait;
                        op_count_q     <= '0;
                        done_pending_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (abort_wr) begin
                        state_q <= StError;
                    end else if (wr_gnt) begin
                        op_count_q <= op_count_inc;
                        if (user_set_done) state_q <= StDone;
                    end else if (rd_gnt) begin
                        rd_addr_q      <= user_addr;
                        done_pending_q <= user_set_done;
                        state_q        <= StRdWait;
                    end else if (user_set_done) begin
                        state_q <= StDone;
                    end
                end
                StRdWait: begin
                    if (abort_wr) begin
                        state_q <= StError;
                    end else if (rd_ready) begin
                        user_rd_data_q  <= swap(rd_data);
                        user_rd_valid_q <= 1'b1;
                        op_count_q      <= op_count_inc;
                        done_pending_q  <= 1'b0;
                        state_q <= (done_pending_q || user_set_done) ? StDone : StWait;
                    end else begin
                        if (user_set_done) done_pending_q <= 1'b1;
                        if (tmo_expire) state_q <= StError;
                    end
                end
                StDone, StError: begin
                    state_q        <= StIdle;
                    done_pending_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign op_count      = op_count_q;
    assign user_rd_data  = user_rd_data_q;
    assign user_rd_valid = user_rd_valid_q;

endmodule
